// File: rtl/ifu.sv
// rtl/ifu.sv - MIPS-lite instruction fetch unit: PC, fetch handshake, next-PC select, fault, retire count
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] instruction,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        npc_jmp,
    input  logic        alu_zero,
    input  logic        jump,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fault,
    output logic [31:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_VALID, S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] npc, br_tgt, jmp_tgt;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jmp_tgt  = {pc_plus4[31:28], instr_q[25:0], 2'b00};

    // A taken branch outranks a jump; a non-taken branch lets the jump through.
    always_comb begin
        npc = pc_plus4;
        if (npc_jmp && alu_zero) begin
            npc = br_tgt;
        end else if (jump) begin
            npc = jmp_tgt;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (im_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (im_rvalid) begin
                    instr_d = im_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (inst_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    pc_d    = npc;
                    state_d = (npc[1:0] != 2'b00) ? S_FAULT : S_FETCH;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs decode straight from the state register so they cannot glitch.
    assign im_req      = (state_q == S_FETCH);
    assign inst_valid  = (state_q == S_VALID);
    assign fault       = (state_q == S_FAULT);
    assign im_addr     = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - self-checking bench for ifu: directed table, corner sequences, randomized model
module tb_ifu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        im_req, im_ready, im_rvalid, inst_valid, inst_ready;
    logic        npc_jmp, alu_zero, jump, fault;
    logic [31:0] im_addr, im_rdata, instruction, pc, pc_plus4, retired_cnt;

    logic        frst = 1'b0;
    logic        f_im_req, f_im_ready, f_im_rvalid, f_inst_valid, f_inst_ready;
    logic        f_npc_jmp, f_alu_zero, f_jump, f_fault;
    logic [31:0] f_im_addr, f_im_rdata, f_instruction, f_pc, f_pc_plus4, f_retired_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] epc;
    logic [31:0] ecnt;

    always #5 clk = ~clk;

    ifu dut (
        .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata), .instruction(instruction),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .npc_jmp(npc_jmp),
        .alu_zero(alu_zero), .jump(jump), .pc(pc), .pc_plus4(pc_plus4),
        .fault(fault), .retired_cnt(retired_cnt)
    );

    // Reset PC chosen so that a branch with imm=16'h8000 lands on 32'h0000_3002.
    ifu #(.RESET_PC(32'h0002_2FFE)) fdut (
        .clk(clk), .rst(frst), .im_req(f_im_req), .im_addr(f_im_addr), .im_ready(f_im_ready),
        .im_rvalid(f_im_rvalid), .im_rdata(f_im_rdata), .instruction(f_instruction),
        .inst_valid(f_inst_valid), .inst_ready(f_inst_ready), .npc_jmp(f_npc_jmp),
        .alu_zero(f_alu_zero), .jump(f_jump), .pc(f_pc), .pc_plus4(f_pc_plus4),
        .fault(f_fault), .retired_cnt(f_retired_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [31:0] ins,
                                            input logic bj, input logic z, input logic j);
        logic [31:0] p4;
        int          off;
        p4 = cur + 32'd4;
        if (bj && z) begin
            off = int'($signed(ins[15:0])) * 4;
            return p4 + 32'(off);
        end
        if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        return p4;
    endfunction

    task automatic fetch(input logic [31:0] data, input int rdy_w, input int rv_w, input logic spur);
        for (int i = 0; i < rdy_w; i++) begin
            chk("fetch_req_hold", {31'd0, im_req}, 32'd1);
            chk("fetch_addr_hold", im_addr, epc);
            im_ready = 1'b0; im_rvalid = spur; im_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        chk("fetch_req", {31'd0, im_req}, 32'd1);
        chk("fetch_addr", im_addr, epc);
        im_ready = 1'b1; im_rvalid = 1'b0;
        @(negedge clk);
        im_ready = 1'b0;
        for (int i = 0; i < rv_w; i++) begin
            chk("wait_req", {31'd0, im_req}, 32'd0);
            chk("wait_valid", {31'd0, inst_valid}, 32'd0);
            @(negedge clk);
        end
        im_rvalid = 1'b1; im_rdata = data;
        @(negedge clk);
        im_rvalid = 1'b0; im_rdata = 32'h0BAD_0BAD;
        chk("valid_rise", {31'd0, inst_valid}, 32'd1);
        chk("instr", instruction, data);
    endtask

    task automatic consume(input logic bj, input logic z, input logic j, input int stall,
                           input logic [31:0] data, input logic [31:0] exp_npc);
        for (int i = 0; i < stall; i++) begin
            inst_ready = 1'b0; npc_jmp = 1'b1; alu_zero = 1'b1; jump = 1'b1;
            @(negedge clk);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_instr", instruction, data);
            chk("stall_pc", pc, epc);
            chk("stall_req", {31'd0, im_req}, 32'd0);
        end
        inst_ready = 1'b1; npc_jmp = bj; alu_zero = z; jump = j;
        @(negedge clk);
        inst_ready = 1'b0; npc_jmp = 1'b1; alu_zero = 1'b1; jump = 1'b1;
        ecnt = ecnt + 32'd1;
        epc  = exp_npc;
        chk("npc", pc, exp_npc);
        chk("pc_plus4", pc_plus4, exp_npc + 32'd4);
        chk("retired", retired_cnt, ecnt);
        chk("post_valid", {31'd0, inst_valid}, 32'd0);
        chk("post_req", {31'd0, im_req}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        bj, z, j;
        int          rdy_w, rv_w, stall;
        logic        spur;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int ph, dly;
        logic [31:0] einstr;
        tbl[0] = '{32'h3C01_1234, 0, 0, 0, 0, 0, 0, 0, 32'h0000_3004};
        tbl[1] = '{32'h0000_0000, 0, 0, 0, 3, 4, 5, 1, 32'h0000_3008};
        tbl[2] = '{32'h1000_FFFF, 1, 1, 0, 0, 0, 0, 0, 32'h0000_3008};
        tbl[3] = '{32'h1000_FFFF, 1, 0, 0, 1, 1, 0, 0, 32'h0000_300C};
        tbl[4] = '{32'h0000_0000, 0, 0, 0, 0, 2, 1, 0, 32'h0000_3010};
        tbl[5] = '{32'h0800_0C10, 0, 0, 1, 0, 0, 0, 0, 32'h0000_3040};
        tbl[6] = '{32'h0800_0C00, 1, 0, 1, 2, 0, 0, 1, 32'h0000_3000};
        tbl[7] = '{32'h1000_0002, 1, 1, 1, 0, 0, 2, 0, 32'h0000_300C};
        tbl[8] = '{32'h1000_0010, 1, 1, 0, 0, 0, 0, 0, 32'h0000_3050};
        tbl[9] = '{32'h0000_1234, 0, 1, 0, 0, 0, 0, 0, 32'h0000_3054};

        im_ready = 0; im_rvalid = 0; im_rdata = 0; inst_ready = 0;
        npc_jmp = 0; alu_zero = 0; jump = 0;
        f_im_ready = 0; f_im_rvalid = 0; f_im_rdata = 0; f_inst_ready = 0;
        f_npc_jmp = 0; f_alu_zero = 0; f_jump = 0;
        #1 rst = 1'b1; frst = 1'b1;
        #1;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_cnt", retired_cnt, 32'd0);
        chk("rst_flags", {28'd0, fault, inst_valid, im_req, 1'b0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("idle_req", {31'd0, im_req}, 32'd0);
        @(negedge clk);
        epc = 32'h0000_3000; ecnt = 32'd0;

        for (int k = 0; k < 10; k++) begin
            fetch(tbl[k].instr, tbl[k].rdy_w, tbl[k].rv_w, tbl[k].spur);
            consume(tbl[k].bj, tbl[k].z, tbl[k].j, tbl[k].stall, tbl[k].instr, tbl[k].exp_npc);
        end

        // Asynchronous reset mid-WAIT, then a stale response from the abandoned request.
        im_ready = 1'b1;
        @(negedge clk);
        im_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0000_3000);
        chk("arst_instr", instruction, 32'd0);
        chk("arst_cnt", retired_cnt, 32'd0);
        chk("arst_flags", {28'd0, fault, inst_valid, im_req, 1'b0}, 32'd0);
        @(negedge clk);
        rst = 1'b0; im_rvalid = 1'b1; im_rdata = 32'h0000_ABCD;
        @(negedge clk);
        chk("stale_req", {31'd0, im_req}, 32'd1);
        chk("stale_instr", instruction, 32'd0);
        @(negedge clk);
        im_rvalid = 1'b0;
        chk("stale_req2", {31'd0, im_req}, 32'd1);
        chk("stale_valid", {31'd0, inst_valid}, 32'd0);
        chk("stale_instr2", instruction, 32'd0);

        // Randomized run against a transaction-level model: 0=fetch 1=wait 2=hold.
        epc = 32'h0000_3000; ecnt = 32'd0; ph = 0; dly = 0; einstr = 32'd0;
        for (int c = 0; c < 1500; c++) begin
            chk("rnd_req", {31'd0, im_req}, {31'd0, ph == 0});
            chk("rnd_valid", {31'd0, inst_valid}, {31'd0, ph == 2});
            chk("rnd_pc", pc, epc);
            chk("rnd_cnt", retired_cnt, ecnt);
            chk("rnd_fault", {31'd0, fault}, 32'd0);
            if (ph == 2) chk("rnd_instr", instruction, einstr);
            im_ready = 1'($urandom); im_rvalid = 1'b0; im_rdata = $urandom;
            inst_ready = 1'($urandom); npc_jmp = 1'($urandom);
            alu_zero = 1'($urandom); jump = 1'($urandom);
            case (ph)
                0: begin
                    if (im_ready) begin ph = 1; dly = int'($urandom_range(0, 3)); end
                    else im_rvalid = 1'($urandom);
                end
                1: begin
                    if (dly == 0) begin im_rvalid = 1'b1; einstr = im_rdata; ph = 2; end
                    else dly--;
                end
                default: begin
                    im_rvalid = 1'($urandom);
                    if (inst_ready) begin
                        epc  = ref_npc(epc, einstr, npc_jmp, alu_zero, jump);
                        ecnt = ecnt + 32'd1;
                        ph   = 0;
                    end
                end
            endcase
            @(negedge clk);
        end
        im_ready = 0; im_rvalid = 0; inst_ready = 0;

        // Misaligned next PC on the second instance: terminal FAULT.
        frst = 1'b0;
        @(negedge clk);
        chk("f_addr", f_im_addr, 32'h0002_2FFE);
        chk("f_req", {31'd0, f_im_req}, 32'd1);
        f_im_ready = 1'b1;
        @(negedge clk);
        f_im_ready = 1'b0; f_im_rvalid = 1'b1; f_im_rdata = 32'h1000_8000;
        @(negedge clk);
        f_im_rvalid = 1'b0;
        chk("f_valid", {31'd0, f_inst_valid}, 32'd1);
        f_inst_ready = 1'b1; f_npc_jmp = 1'b1; f_alu_zero = 1'b1;
        @(negedge clk);
        chk("f_fault", {31'd0, f_fault}, 32'd1);
        chk("f_pc", f_pc, 32'h0000_3002);
        chk("f_cnt", f_retired_cnt, 32'd1);
        f_im_ready = 1'b1; f_im_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("f_hold_req", {31'd0, f_im_req}, 32'd0);
            chk("f_hold_valid", {31'd0, f_inst_valid}, 32'd0);
            chk("f_hold_fault", {31'd0, f_fault}, 32'd1);
            chk("f_hold_pc", f_pc, 32'h0000_3002);
            chk("f_hold_cnt", f_retired_cnt, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
